accelerator_vector_integer_feeder: RTL
======================================

# accelerator_vector_integer_feeder

Sequencing front end for the streamed vector integer units (adder and siblings sharing the START/READY, DATA_A_IN_ENABLE/DATA_B_IN_ENABLE, DATA_OUT_ENABLE element handshake).
- Holds two operand vectors loaded by a host port.
- On START, launches the downstream unit and streams element pairs into it one at a time.
- Captures each streamed result into a result buffer the host reads back, and flags overflow and protocol errors.

## Interface
- DATA_SIZE, 64, element width
- ADDRESS_SIZE, 4, buffer index width; depth = 2**ADDRESS_SIZE
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- START  in  1  run request, honoured only in IDLE
- READY  out  1  one-cycle pulse at end of run
- BUSY  out  1  high in every state except IDLE
- ERROR  out  1  valid with READY; downstream ended run early
- OVERFLOW_OUT  out  1  valid with READY; OR of per-element overflow over the run
- OPERATION  in  1  0 add / 1 subtract, sampled at START
- LENGTH  in  ADDRESS_SIZE+1  element count, sampled at START
- WRITE_ENABLE  in  1  host operand write
- WRITE_SELECT  in  1  0 = operand A buffer, 1 = operand B buffer
- WRITE_ADDRESS  in  ADDRESS_SIZE  host write index
- WRITE_DATA  in  DATA_SIZE  host write data
- READ_ADDRESS  in  ADDRESS_SIZE  result buffer index
- READ_DATA  out  DATA_SIZE  result word, registered, 1-cycle latency
- VECTOR_START  out  1  downstream start pulse
- VECTOR_READY  in  1  downstream run complete
- VECTOR_OPERATION  out  1  latched OPERATION
- VECTOR_SIZE_IN  out  DATA_SIZE  latched length, zero-extended
- VECTOR_DATA_A_IN_ENABLE, VECTOR_DATA_B_IN_ENABLE  out  1  element strobes
- VECTOR_DATA_A_IN, VECTOR_DATA_B_IN  out  DATA_SIZE  element operands
- VECTOR_DATA_OUT_ENABLE  in  1  downstream result valid
- VECTOR_DATA_OUT  in  DATA_SIZE  downstream result
- VECTOR_OVERFLOW_OUT  in  1  downstream overflow for that result

## Operation
- **States:** IDLE, LAUNCH, FETCH, SEND, WAIT, DONE.
- **IDLE:**
  - Host writes accepted into the operand buffer selected by WRITE_SELECT.
  - On START, latch OPERATION and LENGTH, then act on the latched length L:
    - L > depth: saturate L to depth.
    - L == 0: go to DONE (no VECTOR_START, no strobes).
    - Otherwise: index = 0, clear overflow/error accumulators, go to LAUNCH.
- **LAUNCH:** VECTOR_START = 1 for this cycle only; go to FETCH.
- **FETCH:** load VECTOR_DATA_A_IN/B_IN registers from A[index]/B[index]; go to SEND.
- **SEND:** both element strobes high for exactly this cycle, data stable; go to WAIT.
- **WAIT:** the first cycle with VECTOR_DATA_OUT_ENABLE = 1 is the capture cycle:
  - Write VECTOR_DATA_OUT to result[index]; OR VECTOR_OVERFLOW_OUT into the accumulator.
  - If index == L-1, go to DONE; else index+1, go to FETCH.
  - Further VECTOR_DATA_OUT_ENABLE cycles while not in WAIT are ignored.
- **Early end:** VECTOR_READY = 1 in WAIT with no VECTOR_DATA_OUT_ENABLE that cycle, or in FETCH/SEND, sets error and goes to DONE. VECTOR_READY together with DATA_OUT_ENABLE on the last element is the normal finish.
- **DONE:** READY = 1 one cycle, ERROR and OVERFLOW_OUT driven from the accumulators; go to IDLE.
- **Host writes** while BUSY are dropped. READ_ADDRESS is serviced in every state; a same-cycle capture to that index returns the old word.
- **Buffers** are not cleared by reset; contents are held across runs.
- **Reset**, including mid-run: state IDLE. READY, BUSY, ERROR, OVERFLOW_OUT, VECTOR_START, both strobes, VECTOR_OPERATION, VECTOR_SIZE_IN, VECTOR_DATA_A_IN/B_IN, READ_DATA and index all 0. No cleanup of the downstream unit.

## Timing
- START sampled at cycle t:
  - VECTOR_START at t+1.
  - First strobes at t+3.
- Per element: strobe cycle s; result at cycle r > s.
  - Capture at r.
  - Next strobe at r+2 (FETCH at r+1).
- READY one cycle after the final capture.
- READY one cycle after START when L == 0.
- Strobes never assert in two consecutive cycles.
- VECTOR_OPERATION and VECTOR_SIZE_IN are stable from t+1 until the next START.

## Test plan
- **Basic run:** load A = {1,2,3,4}, B = {10,20,30,40}, LENGTH = 4, OPERATION = 0, behavioural adder model with 3-cycle latency -> result = {11,22,33,44}, exactly 4 strobe pairs, READY once, ERROR = 0, OVERFLOW_OUT = 0.
- **Zero length:** LENGTH = 0 -> READY at t+1, no VECTOR_START, no strobes, result buffer unchanged.
- **Saturated length and overflow:** ADDRESS_SIZE = 2, LENGTH = 7 -> VECTOR_SIZE_IN = 4, 4 elements. Model asserts VECTOR_OVERFLOW_OUT on element 2 only -> OVERFLOW_OUT = 1 with READY.
- **Early completion:** model raises VECTOR_READY after element 1 of 4 -> READY with ERROR = 1, result[0..1] written, result[2..3] untouched.
- **Ignored inputs:** host write to A[0] = 99 and a second START during the run -> no effect on the run. A[0] still old value. Second START not honoured.
- **Reset mid-run:** RST held 1 cycle in WAIT -> next cycle all outputs 0, BUSY = 0. A fresh run afterwards completes correctly.

Source files
------------

// File: rtl/accelerator_vector_integer_feeder.sv
// Sequencing front end for streamed vector integer units: buffers two operand
// vectors, streams element pairs downstream one at a time and collects the results.
module accelerator_vector_integer_feeder #(
    parameter int DATA_SIZE    = 64,
    parameter int ADDRESS_SIZE = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    output logic                    BUSY,
    output logic                    ERROR,
    output logic                    OVERFLOW_OUT,
    input  logic                    OPERATION,
    input  logic [ADDRESS_SIZE:0]   LENGTH,
    input  logic                    WRITE_ENABLE,
    input  logic                    WRITE_SELECT,
    input  logic [ADDRESS_SIZE-1:0] WRITE_ADDRESS,
    input  logic [DATA_SIZE-1:0]    WRITE_DATA,
    input  logic [ADDRESS_SIZE-1:0] READ_ADDRESS,
    output logic [DATA_SIZE-1:0]    READ_DATA,
    output logic                    VECTOR_START,
    input  logic                    VECTOR_READY,
    output logic                    VECTOR_OPERATION,
    output logic [DATA_SIZE-1:0]    VECTOR_SIZE_IN,
    output logic                    VECTOR_DATA_A_IN_ENABLE,
    output logic                    VECTOR_DATA_B_IN_ENABLE,
    output logic [DATA_SIZE-1:0]    VECTOR_DATA_A_IN,
    output logic [DATA_SIZE-1:0]    VECTOR_DATA_B_IN,
    input  logic                    VECTOR_DATA_OUT_ENABLE,
    input  logic [DATA_SIZE-1:0]    VECTOR_DATA_OUT,
    input  logic                    VECTOR_OVERFLOW_OUT
);
    localparam int DEPTH = 2 ** ADDRESS_SIZE;
    localparam logic [ADDRESS_SIZE:0]   DEPTH_LEN = (ADDRESS_SIZE + 1)'(DEPTH);
    localparam logic [ADDRESS_SIZE:0]   ONE_LEN   = (ADDRESS_SIZE + 1)'(1);
    localparam logic [ADDRESS_SIZE-1:0] ONE_INDEX = ADDRESS_SIZE'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_FETCH  = 3'd2,
        ST_SEND   = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t                  state_r;
    logic [ADDRESS_SIZE-1:0] index_r;
    logic [ADDRESS_SIZE:0]   length_r;
    logic                    overflow_acc_r;

    logic [DATA_SIZE-1:0] operand_a_r [DEPTH];
    logic [DATA_SIZE-1:0] operand_b_r [DEPTH];
    logic [DATA_SIZE-1:0] result_r    [DEPTH];

    logic [ADDRESS_SIZE:0] start_length_s;
    logic                  last_element_s;
    logic                  capture_s;
    logic                  overflow_next_s;

    // Saturate the requested length and decode the capture condition
    always_comb begin
        if (LENGTH > DEPTH_LEN) begin
            start_length_s = DEPTH_LEN;
        end else begin
            start_length_s = LENGTH;
        end
        last_element_s  = ({1'b0, index_r} == (length_r - ONE_LEN));
        capture_s       = (state_r == ST_WAIT) && VECTOR_DATA_OUT_ENABLE;
        overflow_next_s = overflow_acc_r | VECTOR_OVERFLOW_OUT;
    end

    // Sequencer: launches the downstream unit, walks the element index, reports the run
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r                 <= ST_IDLE;
            index_r                 <= '0;
            length_r                <= '0;
            overflow_acc_r          <= 1'b0;
            READY                   <= 1'b0;
            BUSY                    <= 1'b0;
            ERROR                   <= 1'b0;
            OVERFLOW_OUT            <= 1'b0;
            VECTOR_START            <= 1'b0;
            VECTOR_DATA_A_IN_ENABLE <= 1'b0;
            VECTOR_DATA_B_IN_ENABLE <= 1'b0;
            VECTOR_OPERATION        <= 1'b0;
            VECTOR_SIZE_IN          <= '0;
            VECTOR_DATA_A_IN        <= '0;
            VECTOR_DATA_B_IN        <= '0;
        end else begin
            READY                   <= 1'b0;
            ERROR                   <= 1'b0;
            OVERFLOW_OUT            <= 1'b0;
            VECTOR_START            <= 1'b0;
            VECTOR_DATA_A_IN_ENABLE <= 1'b0;
            VECTOR_DATA_B_IN_ENABLE <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (START) begin
                        VECTOR_OPERATION <= OPERATION;
                        VECTOR_SIZE_IN   <= DATA_SIZE'(start_length_s);
                        length_r         <= start_length_s;
                        overflow_acc_r   <= 1'b0;
                        index_r          <= '0;
                        BUSY             <= 1'b1;
                        if (start_length_s == '0) begin
                            state_r <= ST_DONE;
                            READY   <= 1'b1;
                        end else begin
                            state_r      <= ST_LAUNCH;
                            VECTOR_START <= 1'b1;
                        end
                    end
                end
                ST_LAUNCH: begin
                    state_r <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (VECTOR_READY) begin
                        state_r      <= ST_DONE;
                        READY        <= 1'b1;
                        ERROR        <= 1'b1;
                        OVERFLOW_OUT <= overflow_acc_r;
                    end else begin
                        VECTOR_DATA_A_IN        <= operand_a_r[index_r];
                        VECTOR_DATA_B_IN        <= operand_b_r[index_r];
                        VECTOR_DATA_A_IN_ENABLE <= 1'b1;
                        VECTOR_DATA_B_IN_ENABLE <= 1'b1;
                        state_r                 <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (VECTOR_READY) begin
                        state_r      <= ST_DONE;
                        READY        <= 1'b1;
                        ERROR        <= 1'b1;
                        OVERFLOW_OUT <= overflow_acc_r;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A result on the final element wins over a simultaneous VECTOR_READY
                    if (VECTOR_DATA_OUT_ENABLE) begin
                        overflow_acc_r <= overflow_next_s;
                        if (last_element_s) begin
                            state_r      <= ST_DONE;
                            READY        <= 1'b1;
                            OVERFLOW_OUT <= overflow_next_s;
                        end else begin
                            index_r <= index_r + ONE_INDEX;
                            state_r <= ST_FETCH;
                        end
                    end else if (VECTOR_READY) begin
                        state_r      <= ST_DONE;
                        READY        <= 1'b1;
                        ERROR        <= 1'b1;
                        OVERFLOW_OUT <= overflow_acc_r;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    BUSY    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

    // Operand buffers: host writes land only while idle; contents survive reset
    always_ff @(posedge CLK) begin
        if (WRITE_ENABLE && (state_r == ST_IDLE) && !RST) begin
            if (WRITE_SELECT) begin
                operand_b_r[WRITE_ADDRESS] <= WRITE_DATA;
            end else begin
                operand_a_r[WRITE_ADDRESS] <= WRITE_DATA;
            end
        end
    end

    // Result buffer capture from the downstream unit
    always_ff @(posedge CLK) begin
        if (capture_s && !RST) begin
            result_r[index_r] <= VECTOR_DATA_OUT;
        end
    end

    // Registered host read port; a same-cycle capture returns the previous word
    always_ff @(posedge CLK) begin
        if (RST) begin
            READ_DATA <= '0;
        end else begin
            READ_DATA <= result_r[READ_ADDRESS];
        end
    end

endmodule
